// File: rtl/regfile_writeback.sv
`timescale 1ns/1ps
// Register-file write-port arbiter: ALU results win the port, memory results wait in a FIFO.
// Optional feature macro: WB_PENDING_QUERY_EN builds the pending-write lookup for decode hazards.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_register,
  input  logic [31:0]              alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_register,
  input  logic [31:0]              mem_data,
  input  logic [4:0]               query_register,
  output logic                     query_pending,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [4:0]               write_register,
  output logic                     write_switch,
  output logic [31:0]              write_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       r_mem_reg  [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];

  logic [4:0]       r_wb_reg;
  logic [31:0]      r_wb_data;
  logic             r_wb_switch;

  logic w_full;
  logic w_empty;
  logic w_alu_win;
  logic w_pop;
  logic w_push;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_alu_win = alu_valid && (alu_register != 5'd0);
  assign w_pop     = !w_alu_win && !w_empty;
  // Register-0 loads complete the handshake but are dropped here.
  assign w_push    = mem_valid && !w_full && (mem_register != 5'd0);

  assign mem_ready = !w_full && !reset;
  assign fifo_count = r_count;

  // Stage p0: FIFO bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_wr_ptr]  <= mem_register;
      r_mem_data[r_wr_ptr] <= mem_data;
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_switch <= 1'b0;
      r_wb_reg    <= '0;
      r_wb_data   <= '0;
    end else begin
      r_wb_switch <= w_alu_win || w_pop;
      if (w_alu_win) begin
        r_wb_reg  <= alu_register;
        r_wb_data <= alu_data;
      end else if (w_pop) begin
        r_wb_reg  <= r_mem_reg[r_rd_ptr];
        r_wb_data <= r_mem_data[r_rd_ptr];
      end
    end
  end

  assign write_switch   = r_wb_switch;
  assign write_register = r_wb_reg;
  assign write_data     = r_wb_data;

`ifdef WB_PENDING_QUERY_EN
  logic w_query_hit;

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(PTR_W'(i) - r_rd_ptr)} < r_count) &&
          (r_mem_reg[i] == query_register))
        w_query_hit = 1'b1;
    end
  end

  assign query_pending = w_query_hit && (query_register != 5'd0);
`else
  logic w_unused_query;

  assign w_unused_query = ^query_register;
  assign query_pending  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
`timescale 1ns/1ps
// Bench for regfile_writeback: directed scenarios with literal expectations plus random traffic
// checked every cycle against a queue-based model of the write-port rules.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_register = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_register = '0;
  logic [31:0] mem_data = '0;
  logic [4:0]  query_register = '0;
  logic        query_pending;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [4:0]  write_register;
  logic        write_switch;
  logic [31:0] write_data;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_register(alu_register), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_register(mem_register), .mem_data(mem_data),
    .query_register(query_register), .query_pending(query_pending),
    .fifo_count(fifo_count),
    .write_register(write_register), .write_switch(write_switch), .write_data(write_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending memory writes as {reg, data}; last committed write.
  logic [36:0] q[$];
  logic        m_sw = 1'b0;
  logic [4:0]  m_reg = '0;
  logic [31:0] m_data = '0;
  logic        m_acc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_sw = 1'b0;
      m_reg = '0;
      m_data = '0;
    end else begin
      m_acc = mem_valid && (q.size() < DEPTH);
      if (alu_valid && alu_register != 0) begin
        m_sw = 1'b1; m_reg = alu_register; m_data = alu_data;
      end else if (q.size() > 0) begin
        m_sw = 1'b1; {m_reg, m_data} = q.pop_front();
      end else begin
        m_sw = 1'b0;
      end
      if (m_acc && mem_register != 0) q.push_back({mem_register, mem_data});
    end
  end

  function automatic logic exp_query();
    logic hit = 1'b0;
`ifdef WB_PENDING_QUERY_EN
    foreach (q[i]) if (q[i][36:32] == query_register) hit = 1'b1;
    if (query_register == 0) hit = 1'b0;
`endif
    return hit;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("cmp_write_switch", {31'd0, write_switch}, {31'd0, m_sw});
      chk("cmp_write_register", {27'd0, write_register}, {27'd0, m_reg});
      chk("cmp_write_data", write_data, m_data);
      chk("cmp_fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("cmp_mem_ready", {31'd0, mem_ready}, {31'd0, (!reset && q.size() < DEPTH)});
      chk("cmp_query_pending", {31'd0, query_pending}, {31'd0, exp_query()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] seen[$];
  logic        exp_qp;

  initial begin
`ifdef WB_PENDING_QUERY_EN
    exp_qp = 1'b1;
`else
    exp_qp = 1'b0;
`endif
    // Reset held with traffic present
    alu_valid = 1; alu_register = 5; alu_data = 32'h1234;
    mem_valid = 1; mem_register = 3; mem_data = 32'h55;
    tick();
    started = 1;
    tick();
    chk("rst_switch", {31'd0, write_switch}, 32'd0);
    chk("rst_reg", {27'd0, write_register}, 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    reset = 0; alu_valid = 0; mem_valid = 0;
    #1;
    chk("rst_release_ready", {31'd0, mem_ready}, 32'd1);

    // ALU only
    alu_valid = 1; alu_register = 5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    chk("alu_switch", {31'd0, write_switch}, 32'd1);
    chk("alu_reg", {27'd0, write_register}, 32'd5);
    chk("alu_data", write_data, 32'hDEADBEEF);
    tick();
    chk("alu_switch_drop", {31'd0, write_switch}, 32'd0);
    chk("alu_hold_reg", {27'd0, write_register}, 32'd5);
    alu_valid = 1; alu_register = 0; alu_data = 32'h123;
    tick();
    alu_valid = 0;
    chk("alu_r0_switch", {31'd0, write_switch}, 32'd0);
    chk("alu_r0_hold", write_data, 32'hDEADBEEF);

    // Starvation then drain
    alu_valid = 1; alu_register = 9; alu_data = 32'h900;
    for (int i = 1; i <= 4; i++) begin
      mem_valid = 1; mem_register = 5'(i); mem_data = 32'(i * 32'h11);
      tick();
    end
    mem_valid = 0;
    query_register = 3;
    #1;
    chk("starve_ready", {31'd0, mem_ready}, 32'd0);
    chk("starve_count", 32'(fifo_count), 32'd4);
    chk("starve_query3", {31'd0, query_pending}, {31'd0, exp_qp});
    alu_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_switch", {31'd0, write_switch}, 32'd1);
      chk("drain_reg", {27'd0, write_register}, 32'(i));
      chk("drain_data", write_data, 32'(i * 32'h11));
    end
    query_register = 0;
    tick();
    chk("drain_done", {31'd0, write_switch}, 32'd0);

    // Full FIFO with simultaneous pop
    alu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1; mem_register = 5'(10 + i); mem_data = 32'(32'hA0 + i);
      tick();
    end
    alu_valid = 0; mem_register = 14; mem_data = 32'hE0;
    chk("full_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    chk("full_pop_reg", {27'd0, write_register}, 32'd10);
    chk("full_refused_count", 32'(fifo_count), 32'd3);
    tick();
    mem_valid = 0;
    chk("full_pop2_reg", {27'd0, write_register}, 32'd11);
    chk("full_accept_count", 32'(fifo_count), 32'd3);
    for (int i = 12; i <= 14; i++) begin
      tick();
      chk("full_drain_reg", {27'd0, write_register}, 32'(i));
    end
    chk("full_last_data", write_data, 32'hE0);

    // Register 0 filtering across pointer wrap
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      mem_valid = 1; mem_register = (i % 2 == 1) ? 5'd7 : 5'd0; mem_data = 32'(32'h100 + i);
      tick();
      if (write_switch) seen.push_back(write_data);
    end
    mem_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (write_switch) seen.push_back(write_data);
    end
    chk("wrap_strobes", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      chk("wrap_order", seen[i], 32'(32'h101 + 2 * i));

    // Mid-operation reset
    alu_valid = 1; alu_register = 9;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1; mem_register = 5'(20 + i); mem_data = 32'(i);
      tick();
    end
    mem_valid = 0;
    chk("mid_pre_count", 32'(fifo_count), 32'd3);
    reset = 1;
    #1;
    chk("mid_switch", {31'd0, write_switch}, 32'd0);
    chk("mid_count", 32'(fifo_count), 32'd0);
    chk("mid_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    reset = 0; alu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_strobe", {31'd0, write_switch}, 32'd0);
    end

    // Random traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      alu_valid = ($urandom_range(0, 99) < 45);
      alu_register = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      alu_data = $urandom;
      mem_valid = ($urandom_range(0, 99) < 50);
      mem_register = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      mem_data = $urandom;
      query_register = 5'($urandom_range(0, 7));
      tick();
    end
    reset = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
